// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, access-kind codes, FSM states and decode helpers for the
// memory-stage access unit.
package mem_access_unit_pkg;

    localparam int unsigned NUM_DEV_DEF    = 4;
    localparam int unsigned DEV_W_DEF      = 2;
    localparam int unsigned TIMEOUT_DEF    = 255;
    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned NOWDEVICE_MEMO = 0;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {BE_NONE, BE_SB, BE_SH, BE_SW} be_op_e;
    typedef enum logic [2:0] {ME_NONE, ME_LB, ME_LBU, ME_LH, ME_LHU, ME_LW} me_op_e;
    typedef enum logic [1:0] {MA_IDLE, MA_WAIT, MA_DONE} ma_state_e;

    // Access fields held stable for the device while an IO transfer is open.
    typedef struct packed {
        be_op_e     be_op;
        me_op_e     me_op;
        logic [1:0] off;
    } acc_t;

    function automatic be_op_e be_op_of(input logic [5:0] op);
        case (op)
            OP_SB:   return BE_SB;
            OP_SH:   return BE_SH;
            OP_SW:   return BE_SW;
            default: return BE_NONE;
        endcase
    endfunction

    function automatic me_op_e me_op_of(input logic [5:0] op);
        case (op)
            OP_LB:   return ME_LB;
            OP_LBU:  return ME_LBU;
            OP_LH:   return ME_LH;
            OP_LHU:  return ME_LHU;
            OP_LW:   return ME_LW;
            default: return ME_NONE;
        endcase
    endfunction

    function automatic logic aligned_of(input be_op_e b, input me_op_e m, input logic [1:0] off);
        if (b == BE_SW || m == ME_LW) return (off == 2'b00);
        if (b == BE_SH || m == ME_LH || m == ME_LHU) return !off[0];
        return 1'b1;
    endfunction

    function automatic logic [3:0] be_of(input be_op_e b, input logic [1:0] off);
        case (b)
            BE_SB:   return 4'b0001 << off;
            BE_SH:   return 4'b0011 << {off[1], 1'b0};
            BE_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input be_op_e b, input logic [31:0] wd);
        case (b)
            BE_SB:   return {4{wd[7:0]}};
            BE_SH:   return {2{wd[15:0]}};
            BE_SW:   return wd;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// M-stage to device-bridge bundle; master drives the stage side, slave is the unit.
interface mem_access_unit_if #(
    parameter int unsigned NUM_DEV = 4,
    parameter int unsigned DEV_W   = 2
);
    logic                    valid;
    logic                    flush;
    logic [5:0]              opcode;
    logic [31:0]             addr;
    logic [31:0]             wdata;
    logic [DEV_W-1:0]        dev_sel;
    logic [NUM_DEV*32-1:0]   rdata_bus;
    logic [NUM_DEV-1:0]      io_ack;
    logic                    mem_we;
    logic [NUM_DEV-1:0]      io_req;
    logic [NUM_DEV-1:0]      io_we;
    logic [3:0]              be;
    logic [31:0]             wdata_out;
    logic [31:0]             ld_data;
    logic                    stall;
    logic                    adel;
    logic                    ades;
    logic                    bus_err;

    modport master (
        output valid, flush, opcode, addr, wdata, dev_sel, rdata_bus, io_ack,
        input  mem_we, io_req, io_we, be, wdata_out, ld_data, stall, adel, ades, bus_err
    );

    modport slave (
        input  valid, flush, opcode, addr, wdata, dev_sel, rdata_bus, io_ack,
        output mem_we, io_req, io_we, be, wdata_out, ld_data, stall, adel, ades, bus_err
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/half of a word and sign- or zero-extends it.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  me_op_e      op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    output logic [31:0] res_o
);
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = word_i[7:0];
        case (off_i)
            2'd1:    byte_c = word_i[15:8];
            2'd2:    byte_c = word_i[23:16];
            2'd3:    byte_c = word_i[31:24];
            default: byte_c = word_i[7:0];
        endcase
        half_c = off_i[1] ? word_i[31:16] : word_i[15:0];

        res_o = 32'h0;
        case (op_i)
            ME_LB:   res_o = {{24{byte_c[7]}}, byte_c};
            ME_LBU:  res_o = {24'h0, byte_c};
            ME_LH:   res_o = {{16{half_c[15]}}, half_c};
            ME_LHU:  res_o = {16'h0, half_c};
            ME_LW:   res_o = word_i;
            default: res_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: single-cycle data memory on device 0, multi-cycle
// req/ack IO with stall, timeout and alignment exceptions on the others.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned NUM_DEV = NUM_DEV_DEF,
    parameter int unsigned DEV_W   = DEV_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input logic             clk,
    input logic             reset,
    mem_access_unit_if.slave bus
);
    ma_state_e        state_q, state_d;
    acc_t             acc_q, acc_d;
    logic [DEV_W-1:0] dev_q, dev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rbuf_q, rbuf_d;

    be_op_e       be_op_c;
    me_op_e       me_op_c;
    logic         is_ld_c, is_st_c, aligned_c, access_c, to_mem_c;
    me_op_e       ext_op_c;
    logic [1:0]   ext_off_c;
    logic [31:0]  ext_src_c, ext_res_c;
    logic               mem_we_c, stall_c, adel_c, ades_c, bus_err_c;
    logic [NUM_DEV-1:0] io_req_c, io_we_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic               unused_addr;

    assign unused_addr = ^bus.addr[31:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MA_IDLE;
            acc_q   <= '{be_op: BE_NONE, me_op: ME_NONE, off: 2'b00};
            dev_q   <= '0;
            cnt_q   <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dev_q   <= dev_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        dev_d     = dev_q;
        cnt_d     = cnt_q;
        rbuf_d    = rbuf_q;
        mem_we_c  = 1'b0;
        io_req_c  = '0;
        io_we_c   = '0;
        be_c      = 4'b0000;
        wdata_c   = 32'h0;
        stall_c   = 1'b0;
        adel_c    = 1'b0;
        ades_c    = 1'b0;
        bus_err_c = 1'b0;
        ext_op_c  = ME_NONE;
        ext_off_c = bus.addr[1:0];
        ext_src_c = bus.rdata_bus[31:0];

        be_op_c   = be_op_of(bus.opcode);
        me_op_c   = me_op_of(bus.opcode);
        is_ld_c   = (me_op_c != ME_NONE);
        is_st_c   = (be_op_c != BE_NONE);
        aligned_c = aligned_of(be_op_c, me_op_c, bus.addr[1:0]);
        access_c  = bus.valid & (is_ld_c | is_st_c) & ~bus.flush & aligned_c;
        to_mem_c  = (bus.dev_sel == DEV_W'(NOWDEVICE_MEMO));

        case (state_q)
            MA_IDLE: begin
                adel_c = bus.valid & ~bus.flush & is_ld_c & ~aligned_c;
                ades_c = bus.valid & ~bus.flush & is_st_c & ~aligned_c;
                if (access_c) begin
                    be_c    = be_of(be_op_c, bus.addr[1:0]);
                    wdata_c = wdata_rep(be_op_c, bus.wdata);
                    if (to_mem_c) begin
                        mem_we_c = is_st_c;
                        ext_op_c = me_op_c;
                    end else begin
                        stall_c = 1'b1;
                        state_d = MA_WAIT;
                        dev_d   = bus.dev_sel;
                        acc_d   = '{be_op: be_op_c, me_op: me_op_c, off: bus.addr[1:0]};
                        cnt_d   = '0;
                    end
                end
            end
            MA_WAIT: begin
                be_c    = be_of(acc_q.be_op, acc_q.off);
                wdata_c = wdata_rep(acc_q.be_op, bus.wdata);
                stall_c = 1'b1;
                cnt_d   = CNT_W'(cnt_q + CNT_W'(1));
                if (bus.flush) begin
                    state_d = MA_IDLE;
                end else begin
                    io_req_c[dev_q] = 1'b1;
                    io_we_c[dev_q]  = (acc_q.be_op != BE_NONE);
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus.io_ack[dev_q]) begin
                        rbuf_d  = bus.rdata_bus[32*int'(dev_q) +: 32];
                        state_d = MA_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                        bus_err_c = 1'b1;
                        state_d   = MA_IDLE;
                    end
                end
            end
            MA_DONE: begin
                be_c      = be_of(acc_q.be_op, acc_q.off);
                wdata_c   = wdata_rep(acc_q.be_op, bus.wdata);
                ext_op_c  = acc_q.me_op;
                ext_off_c = acc_q.off;
                ext_src_c = rbuf_q;
                state_d   = MA_IDLE;
            end
            default: state_d = MA_IDLE;
        endcase

        // Outputs stay quiet for the whole reset cycle regardless of state.
        if (reset) begin
            mem_we_c  = 1'b0;
            io_req_c  = '0;
            io_we_c   = '0;
            be_c      = 4'b0000;
            wdata_c   = 32'h0;
            stall_c   = 1'b0;
            adel_c    = 1'b0;
            ades_c    = 1'b0;
            bus_err_c = 1'b0;
            ext_op_c  = ME_NONE;
        end
    end

    mem_access_unit_load_extend u_load_extend (
        .op_i   (ext_op_c),
        .off_i  (ext_off_c),
        .word_i (ext_src_c),
        .res_o  (ext_res_c)
    );

    assign bus.mem_we    = mem_we_c;
    assign bus.io_req    = io_req_c;
    assign bus.io_we     = io_we_c;
    assign bus.be        = be_c;
    assign bus.wdata_out = wdata_c;
    assign bus.ld_data   = ext_res_c;
    assign bus.stall     = stall_c;
    assign bus.adel      = adel_c;
    assign bus.ades      = ades_c;
    assign bus.bus_err   = bus_err_c;
endmodule
